gfx_rom_arbiter: RTL and testbench

//  Shares one graphics ROM port between three tile-layer fetchers (text, fg, bg) and the sprite fetcher.

---
 rtl/gfx_rom_arbiter.sv | 236 +++++++++++++++++++++++
 tb/tb_gfx_rom_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/gfx_rom_arbiter.sv
// Graphics ROM port arbiter: three tile fetchers and one sprite fetcher share a
// single-outstanding ROM port, with blank-driven priority and a fill-data watchdog.
module gfx_rom_arbiter #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 63
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hbl,
  input  logic                  vbl,
  input  logic [3:0]            req,
  input  logic [4*ADDR_W-1:0]   req_addr,
  output logic [3:0]            ack,
  output logic [DATA_W-1:0]     rdata,
  output logic                  mem_req,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  busy,
  output logic [1:0]            grant_id,
  output logic                  timeout_err
);

  localparam int WD_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WDOG_MAX = WD_W'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [3:0]          ack_q, ack_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          grant_id_q, grant_id_d;
  logic                timeout_err_q, timeout_err_d;
  logic [1:0]          rr_ptr_q, rr_ptr_d;
  logic [WD_W-1:0]     wdog_q, wdog_d;

  logic [ADDR_W-1:0]   client_addr_s [4];
  logic [1:0]          rr_first_s, rr_second_s, rr_third_s;
  logic                rr_hit_s;
  logic [1:0]          rr_idx_s;
  logic                blank_s;
  logic                grant_valid_s;
  logic [1:0]          grant_s;
  logic                wdog_expired_s;

  // Split the packed client address bus into per-client words.
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      client_addr_s[n] = req_addr[n*ADDR_W +: ADDR_W];
    end
  end

  // Round-robin search order among tile clients, starting just after rr_ptr.
  always_comb begin
    case (rr_ptr_q)
      2'd0: begin
        rr_first_s  = 2'd1;
        rr_second_s = 2'd2;
        rr_third_s  = 2'd0;
      end
      2'd1: begin
        rr_first_s  = 2'd2;
        rr_second_s = 2'd0;
        rr_third_s  = 2'd1;
      end
      default: begin
        rr_first_s  = 2'd0;
        rr_second_s = 2'd1;
        rr_third_s  = 2'd2;
      end
    endcase
  end

  // First requesting tile client in round-robin order.
  always_comb begin
    rr_hit_s = 1'b0;
    rr_idx_s = 2'd0;
    if (req[rr_first_s]) begin
      rr_hit_s = 1'b1;
      rr_idx_s = rr_first_s;
    end else if (req[rr_second_s]) begin
      rr_hit_s = 1'b1;
      rr_idx_s = rr_second_s;
    end else if (req[rr_third_s]) begin
      rr_hit_s = 1'b1;
      rr_idx_s = rr_third_s;
    end else begin
      rr_hit_s = 1'b0;
      rr_idx_s = 2'd0;
    end
  end

  assign blank_s = hbl | vbl;

  // Sprites lead during blanking, tile layers lead during active display.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_s       = 2'd0;
    if (blank_s && req[3]) begin
      grant_valid_s = 1'b1;
      grant_s       = 2'd3;
    end else if (rr_hit_s) begin
      grant_valid_s = 1'b1;
      grant_s       = rr_idx_s;
    end else if (req[3]) begin
      grant_valid_s = 1'b1;
      grant_s       = 2'd3;
    end else begin
      grant_valid_s = 1'b0;
      grant_s       = 2'd0;
    end
  end

  assign wdog_expired_s = (wdog_q == WDOG_MAX);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid_s) begin
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (mem_ack || wdog_expired_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM output / datapath next values.
  always_comb begin
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    ack_d         = 4'b0000;
    rdata_d       = rdata_q;
    grant_id_d    = grant_id_q;
    timeout_err_d = timeout_err_q;
    rr_ptr_d      = rr_ptr_q;
    wdog_d        = wdog_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid_s) begin
          grant_id_d = grant_s;
          mem_addr_d = client_addr_s[grant_s];
          mem_req_d  = 1'b1;
          wdog_d     = {WD_W{1'b0}};
          if (grant_s != 2'd3) begin
            rr_ptr_d = grant_s;
          end else begin
            rr_ptr_d = rr_ptr_q;
          end
        end else begin
          mem_req_d = 1'b0;
        end
      end
      ST_BUSY: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          rdata_d   = mem_rdata;
          ack_d     = 4'b0001 << grant_id_q;
        end else if (wdog_expired_s) begin
          // Watchdog abort: complete the client with fill data.
          mem_req_d     = 1'b0;
          rdata_d       = {DATA_W{1'b1}};
          ack_d         = 4'b0001 << grant_id_q;
          timeout_err_d = 1'b1;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      ST_DONE: begin
        ack_d = 4'b0000;
      end
      default: begin
        mem_req_d = 1'b0;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req_q     <= 1'b0;
      mem_addr_q    <= {ADDR_W{1'b0}};
      ack_q         <= 4'b0000;
      rdata_q       <= {DATA_W{1'b0}};
      grant_id_q    <= 2'd0;
      timeout_err_q <= 1'b0;
      rr_ptr_q      <= 2'd2;
      wdog_q        <= {WD_W{1'b0}};
    end else begin
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      ack_q         <= ack_d;
      rdata_q       <= rdata_d;
      grant_id_q    <= grant_id_d;
      timeout_err_q <= timeout_err_d;
      rr_ptr_q      <= rr_ptr_d;
      wdog_q        <= wdog_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign ack         = ack_q;
  assign rdata       = rdata_q;
  assign grant_id    = grant_id_q;
  assign timeout_err = timeout_err_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gfx_rom_arbiter.sv
// Randomized bench for gfx_rom_arbiter, compared every cycle against a
// transaction-level reference model of the arbitration rules.
module tb_gfx_rom_arbiter;

  localparam int ADDR_W  = 20;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 63;

  logic                clk = 1'b0;
  logic                reset;
  logic                hbl, vbl;
  logic [3:0]          req;
  logic [4*ADDR_W-1:0] req_addr;
  logic [3:0]          ack;
  logic [DATA_W-1:0]   rdata;
  logic                mem_req;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_ack;
  logic [DATA_W-1:0]   mem_rdata;
  logic                busy;
  logic [1:0]          grant_id;
  logic                timeout_err;

  logic [ADDR_W-1:0]   cl_addr [4];

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int                m_phase;   // 0 waiting for a request, 1 ROM access, 2 completion cycle
  int                m_client;
  int                m_rr;
  int                m_wait;
  logic              m_mem_req;
  logic [ADDR_W-1:0] m_mem_addr;
  logic [3:0]        m_ack;
  logic [DATA_W-1:0] m_rdata;
  logic [1:0]        m_grant;
  logic              m_terr;

  always #5 clk = ~clk;

  gfx_rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .hbl        (hbl),
    .vbl        (vbl),
    .req        (req),
    .req_addr   (req_addr),
    .ack        (ack),
    .rdata      (rdata),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .grant_id   (grant_id),
    .timeout_err(timeout_err)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs the DUT just sampled.
  task automatic model_step();
    int g;
    int c;
    g = -1;
    if (reset) begin
      m_phase    = 0;
      m_mem_req  = 1'b0;
      m_mem_addr = '0;
      m_ack      = 4'b0000;
      m_rdata    = '0;
      m_grant    = 2'd0;
      m_terr     = 1'b0;
      m_rr       = 2;
      m_wait     = 0;
    end else if (m_phase == 0) begin
      if ((hbl || vbl) && req[3]) begin
        g = 3;
      end else begin
        for (int k = 1; k <= 3; k++) begin
          c = (m_rr + k) % 3;
          if (g < 0 && req[c]) g = c;
        end
        if (g < 0 && req[3]) g = 3;
      end
      if (g >= 0) begin
        m_client   = g;
        m_grant    = 2'(g);
        m_mem_addr = cl_addr[g];
        m_mem_req  = 1'b1;
        m_wait     = 0;
        m_phase    = 1;
        if (g < 3) m_rr = g;
      end
    end else if (m_phase == 1) begin
      if (mem_ack) begin
        m_rdata   = mem_rdata;
        m_ack     = 4'b0001 << m_client;
        m_mem_req = 1'b0;
        m_phase   = 2;
      end else if (m_wait == TIMEOUT) begin
        m_rdata   = '1;
        m_terr    = 1'b1;
        m_ack     = 4'b0001 << m_client;
        m_mem_req = 1'b0;
        m_phase   = 2;
      end else begin
        m_wait++;
      end
    end else begin
      m_ack   = 4'b0000;
      m_phase = 0;
    end
  endtask

  task automatic compare_all();
    check_eq("mem_req",     64'(mem_req),     64'(m_mem_req));
    check_eq("mem_addr",    64'(mem_addr),    64'(m_mem_addr));
    check_eq("ack",         64'(ack),         64'(m_ack));
    check_eq("rdata",       64'(rdata),       64'(m_rdata));
    check_eq("busy",        64'(busy),        64'(m_phase != 0));
    check_eq("grant_id",    64'(grant_id),    64'(m_grant));
    check_eq("timeout_err", 64'(timeout_err), 64'(m_terr));
  endtask

  // mode: 0 tiles always requesting/no blank, 1 random, 2 ROM stalled,
  //       3 all clients requesting in blank, 4 hold reset
  task automatic gen_inputs(input int mode);
    logic [3:0] r;
    reset = (mode == 4) || (mode == 1 && $urandom_range(0, 299) == 0);
    r = req;
    for (int n = 0; n < 4; n++) begin
      if (ack[n]) begin
        r[n] = 1'b0;
      end else if (!r[n]) begin
        if ((mode == 0 && n < 3) || mode == 3 ||
            ((mode == 1 || mode == 2) && $urandom_range(0, 3) == 0)) begin
          r[n]       = 1'b1;
          cl_addr[n] = ADDR_W'($urandom);
        end
      end
    end
    req = r;
    for (int n = 0; n < 4; n++) req_addr[n*ADDR_W +: ADDR_W] = cl_addr[n];
    case (mode)
      0: begin hbl = 1'b0; vbl = 1'b0; end
      3: begin hbl = 1'b1; vbl = 1'b0; end
      default: begin
        hbl = ($urandom_range(0, 3) == 0);
        vbl = ($urandom_range(0, 7) == 0);
      end
    endcase
    if (mode == 2) mem_ack = 1'b0;
    else if (mem_req) mem_ack = ($urandom_range(0, 2) == 0);
    else mem_ack = ($urandom_range(0, 7) == 0);
    mem_rdata = $urandom;
  endtask

  task automatic run(input int cycles, input int mode);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      model_step();
      compare_all();
      gen_inputs(mode);
    end
  endtask

  initial begin
    reset     = 1'b1;
    hbl       = 1'b0;
    vbl       = 1'b0;
    req       = 4'b0000;
    req_addr  = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    for (int n = 0; n < 4; n++) cl_addr[n] = '0;
    run(3, 4);
    run(200, 0);
    run(100, 3);
    run(3000, 1);
    run(300, 2);
    run(2, 4);
    run(300, 0);
    run(1000, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
